rom_burst_arbiter: RTL and testbench

- Shares one synchronous ROM read port between NREQ requesters using round-robin arbitration.
- The ROM has 1-cycle registered read latency and no enable.
- A granted requester receives a burst of LEN consecutive words, one per cycle; the burst is never preempted.
- Sits between sprite/pattern fetch engines and a single ROM instance; drives the ROM address and steers the returned data.

---
 rtl/rom_burst_arbiter.sv | 139 +++++++++++++
 tb/tb_rom_burst_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_arbiter.sv
// ============================================================================
//  Module   : rom_burst_arbiter
//  Purpose  : Round-robin sharing of one 1-cycle-latency ROM read port among
//             NREQ burst requesters; bursts are never preempted.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_burst_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 256,
    parameter int MAXLEN = 16,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int LENW  = $clog2(MAXLEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*ADDRW-1:0]   req_addr_i,
    input  logic [NREQ*LENW-1:0]    req_len_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [ADDRW-1:0]        rom_addr_o,
    input  logic [WIDTH-1:0]        rom_data_i,
    output logic [NREQ-1:0]         rsp_valid_o,
    output logic                    rsp_last_o,
    output logic [WIDTH-1:0]        rsp_data_o,
    output logic                    busy_o
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     win_q;
    logic [ADDRW-1:0]   rom_addr_q;
    logic [LENW-1:0]    cnt_q;
    logic [NREQ-1:0]    rsp_valid_q;
    logic               rsp_last_q;
    logic               busy_q;

    logic               any_d;
    logic [IDW-1:0]     win_d;
    logic [ADDRW-1:0]   base_d;
    logic [LENW-1:0]    len_raw_d;
    logic [LENW-1:0]    len_d;

    // Cyclic search starting at the pointer: first hit wins.
    always_comb begin
        any_d = 1'b0;
        win_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_d && req_i[(int'(ptr_q) + i) % NREQ]) begin
                any_d = 1'b1;
                win_d = IDW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        base_d    = req_addr_i[int'(win_d)*ADDRW +: ADDRW];
        len_raw_d = req_len_i[int'(win_d)*LENW +: LENW];
        if (len_raw_d == '0) begin
            len_d = LENW'(1);
        end else if (len_raw_d > LENW'(MAXLEN)) begin
            len_d = LENW'(MAXLEN);
        end else begin
            len_d = len_raw_d;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (state_q == S_IDLE && any_d) begin
            gnt_o[win_d] = 1'b1;
        end
    end

    // cnt_q holds the number of addresses still to issue after the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            rom_addr_q  <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            rsp_last_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_d) begin
                        win_q      <= win_d;
                        rom_addr_q <= base_d;
                        cnt_q      <= len_d - 1'b1;
                        busy_q     <= 1'b1;
                        ptr_q      <= (int'(win_d) == NREQ - 1) ? '0 : win_d + 1'b1;
                        state_q    <= S_BURST;
                    end
                end
                S_BURST: begin
                    rsp_valid_q[win_q] <= 1'b1;
                    if (cnt_q == '0) begin
                        rsp_last_q <= 1'b1;
                        state_q    <= S_DRAIN;
                    end else begin
                        cnt_q      <= cnt_q - 1'b1;
                        rom_addr_q <= (int'(rom_addr_q) == DEPTH - 1) ? '0 : rom_addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr_o  = rom_addr_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_last_o  = rsp_last_q;
    assign rsp_data_o  = rom_data_i;
    assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_burst_arbiter.sv
// ============================================================================
//  Module   : tb_rom_burst_arbiter
//  Purpose  : Self-checking bench for rom_burst_arbiter (ROM holds mem[a]=a).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_burst_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 256;
    localparam int MAXLEN = 16;
    localparam int ADDRW  = 8;
    localparam int LENW   = 5;
    localparam int MAXC   = 8192;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*ADDRW-1:0] req_addr = '0;
    logic [NREQ*LENW-1:0]  req_len = '0;
    logic [NREQ-1:0]       gnt_o;
    logic [ADDRW-1:0]      rom_addr_o;
    logic [WIDTH-1:0]      rom_data;
    logic [NREQ-1:0]       rsp_valid_o;
    logic                  rsp_last_o;
    logic [WIDTH-1:0]      rsp_data_o;
    logic                  busy_o;

    rom_burst_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAXLEN(MAXLEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_addr_i(req_addr),
        .req_len_i(req_len), .gnt_o(gnt_o), .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data), .rsp_valid_o(rsp_valid_o),
        .rsp_last_o(rsp_last_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // ROM contents: mem[a] = a, one-cycle registered read, no enable.
    always @(posedge clk) rom_data <= WIDTH'(rom_addr_o);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // On each accepted request the whole burst is laid out on a cycle
    // timeline; every cycle the DUT outputs are compared to that timeline.
    int e_addr [MAXC];
    int e_vld  [MAXC];
    int e_dat  [MAXC];
    bit e_last [MAXC];
    bit e_busy [MAXC];
    int m_ptr = 0;
    int m_free = 0;
    int m_last_addr = 0;

    always @(negedge clk) begin
        int c, w, base, len, egnt, ev;
        c = cyc;
        if (c + MAXLEN + 4 < MAXC) begin
            if (!rst_n) begin
                for (int k = c; k < c + MAXLEN + 4; k++) begin
                    e_addr[k] = -1; e_vld[k] = -1; e_last[k] = 0; e_busy[k] = 0;
                end
                m_ptr = 0; m_free = c + 1; m_last_addr = 0;
                chk("rst_gnt", int'(gnt_o), 0);
                chk("rst_rom_addr", int'(rom_addr_o), 0);
                chk("rst_rsp_valid", int'(rsp_valid_o), 0);
                chk("rst_rsp_last", int'(rsp_last_o), 0);
                chk("rst_busy", int'(busy_o), 0);
            end else begin
                egnt = 0;
                if (c >= m_free && req != '0) begin
                    w = -1;
                    for (int i = 0; i < NREQ; i++)
                        if (w < 0 && req[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
                    egnt = 1 << w;
                    base = int'(req_addr[w*ADDRW +: ADDRW]);
                    len  = int'(req_len[w*LENW +: LENW]);
                    if (len == 0) len = 1;
                    if (len > MAXLEN) len = MAXLEN;
                    for (int k = 0; k < len; k++) begin
                        e_addr[c+1+k] = (base + k) % DEPTH;
                        e_vld[c+2+k]  = w;
                        e_dat[c+2+k]  = (base + k) % DEPTH;
                    end
                    e_last[c+len+1] = 1;
                    for (int k = 1; k <= len + 1; k++) e_busy[c+k] = 1;
                    m_free = c + len + 2;
                    m_ptr  = (w + 1) % NREQ;
                end
                if (e_addr[c] >= 0) m_last_addr = e_addr[c];
                ev = (e_vld[c] < 0) ? 0 : (1 << e_vld[c]);
                chk("gnt", int'(gnt_o), egnt);
                chk("rom_addr", int'(rom_addr_o), m_last_addr);
                chk("rsp_valid", int'(rsp_valid_o), ev);
                chk("rsp_last", int'(rsp_last_o), int'(e_last[c]));
                chk("busy", int'(busy_o), int'(e_busy[c]));
                if (e_vld[c] >= 0) chk("rsp_data", int'(rsp_data_o), e_dat[c]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input bit v, input int addr, input int len);
        req[id] = v;
        req_addr[id*ADDRW +: ADDRW] = ADDRW'(addr);
        req_len[id*LENW +: LENW]    = LENW'(len);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_o && k < 40) begin
            tick();
            k++;
        end
        if (busy_o) chk("idle_timeout", 1, 0);
        tick();
    endtask

    function automatic int onehot_id(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    typedef struct {
        int id;
        int addr;
        int len;
        int beats;
        int lastd;
    } vec_t;

    vec_t vt [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not terminate, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int gcyc, scyc, beats, lastd, sawlast;
        int gid [5];
        int gc [5];
        int rr_exp [5];
        int n, first, fc, saw1, g0, nb, stale;
        logic [NREQ-1:0] g;

        vt[0] = '{id: 2, addr: 'h10, len: 4,  beats: 4,  lastd: 'h13};
        vt[1] = '{id: 0, addr: 'hFE, len: 4,  beats: 4,  lastd: 'h01};
        vt[2] = '{id: 1, addr: 'h33, len: 0,  beats: 1,  lastd: 'h33};
        vt[3] = '{id: 3, addr: 'h80, len: 31, beats: 16, lastd: 'h8F};
        vt[4] = '{id: 2, addr: 'hF0, len: 16, beats: 16, lastd: 'hFF};
        vt[5] = '{id: 1, addr: 'h05, len: 1,  beats: 1,  lastd: 'h05};
        rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 2; rr_exp[3] = 3; rr_exp[4] = 0;

        for (int k = 0; k < MAXC; k++) begin
            e_addr[k] = -1; e_vld[k] = -1; e_dat[k] = 0; e_last[k] = 0; e_busy[k] = 0;
        end

        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ---- table-driven single bursts ----
        for (int t = 0; t < 6; t++) begin
            scyc = cyc;
            set_req(vt[t].id, 1'b1, vt[t].addr, vt[t].len);
            gcyc = -1;
            for (int w = 0; w < 4; w++) begin
                if (gcyc < 0) begin
                    @(negedge clk);
                    if (gnt_o[vt[t].id]) gcyc = cyc;
                    else tick();
                end
            end
            chk("vec_gnt_latency", gcyc - scyc, 0);
            tick();
            req = '0;
            beats = 0; lastd = -1; sawlast = 0;
            for (int k = 0; k < MAXLEN + 6; k++) begin
                if (!sawlast) begin
                    @(negedge clk);
                    if (rsp_valid_o[vt[t].id]) begin
                        beats++;
                        lastd = int'(rsp_data_o);
                    end
                    if (rsp_last_o) sawlast = 1;
                end
            end
            chk("vec_beats", beats, vt[t].beats);
            chk("vec_last_data", lastd, vt[t].lastd);
            chk("vec_saw_last", sawlast, 1);
            tick();
        end

        // ---- round robin, all requesters held, len=1 ----
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16 * i + 1, 1);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            if (n < 5) begin
                @(negedge clk);
                if (gnt_o != '0) begin
                    gid[n] = onehot_id(gnt_o);
                    gc[n]  = cyc;
                    n++;
                end
                tick();
            end
        end
        req = '0;
        chk("rr_count", n, 5);
        for (int i = 0; i < 5; i++) if (i < n) chk("rr_order", gid[i], rr_exp[i]);
        for (int i = 1; i < 5; i++) if (i < n) chk("rr_spacing", gc[i] - gc[i-1], 3);
        wait_idle();

        // ---- withdraw during burst / raise mid-burst ----
        set_req(0, 1'b1, 'h40, 8);
        g0 = -1;
        for (int w = 0; w < 4; w++) begin
            if (g0 < 0) begin
                @(negedge clk);
                if (gnt_o[0]) g0 = cyc;
                else tick();
            end
        end
        chk("wd_gnt0", (g0 >= 0) ? 1 : 0, 1);
        tick(); req[0] = 1'b0;
        tick(); set_req(1, 1'b1, 'h50, 3);
        tick(); tick(); req[1] = 1'b0;
        tick(); set_req(3, 1'b1, 'h60, 2);
        first = -1; fc = -1; saw1 = 0;
        for (int k = 0; k < 20; k++) begin
            if (first < 0) begin
                @(negedge clk);
                if (gnt_o[1]) saw1 = 1;
                if (gnt_o != '0) begin
                    first = onehot_id(gnt_o);
                    fc = cyc;
                end
                tick();
            end
        end
        req = '0;
        chk("wd_next_winner", first, 3);
        chk("wd_grant_cycle", fc - g0, 10);
        chk("wd_req1_never", saw1, 0);
        wait_idle();

        // ---- reset abort in the third beat ----
        set_req(2, 1'b1, 'h20, 8);
        gcyc = -1;
        for (int w = 0; w < 4; w++) begin
            if (gcyc < 0) begin
                @(negedge clk);
                if (gnt_o[2]) gcyc = cyc;
                else tick();
            end
        end
        chk("abort_gnt", (gcyc >= 0) ? 1 : 0, 1);
        tick(); req = '0;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (nb < 3) begin
                @(negedge clk);
                if (rsp_valid_o[2]) nb++;
            end
        end
        chk("abort_third_beat", nb, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", int'(rsp_valid_o), 0);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_rom_addr", int'(rom_addr_o), 0);
        tick(); tick();
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid_o != '0 || busy_o) stale++;
            tick();
        end
        chk("abort_no_stale", stale, 0);
        set_req(0, 1'b1, 'h70, 2);
        set_req(3, 1'b1, 'h90, 2);
        @(negedge clk);
        chk("abort_first_winner", onehot_id(gnt_o), 0);
        tick();
        req = '0;
        wait_idle();

        // ---- randomized traffic against the model ----
        for (int n2 = 0; n2 < 1500; n2++) begin
            @(negedge clk);
            g = gnt_o;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (g[i] || !req[i]) begin
                    set_req(i, ($urandom % 3) == 0, int'($urandom_range(0, 255)),
                            int'($urandom_range(0, 20)));
                end else if (($urandom % 16) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        wait_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
